// File: rtl/data_port_arbiter_pkg.sv
// Shared types and address map for the data-port arbiter.
package mem_arb_pkg;

  // Arbiter FSM: IDLE serves the CPU first, BURST keeps the port for the I/O engine.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Output segment reachable by the I/O engine: [IO_BASE, IO_END).
  localparam int unsigned IO_BASE      = 1056;
  localparam int unsigned IO_END       = 1806;
  // The startIO flag sits just past the window and is read-only for I/O,
  // so it is rejected by the same upper-bound test.
  localparam int unsigned STARTIO_ADDR = 1806;

  // True when an I/O beat address lies inside the output segment.
  function automatic logic io_addr_legal(input logic [31:0] addr);
    return (addr >= IO_BASE) && (addr < IO_END);
  endfunction

endpackage

// File: rtl/data_port_arbiter_if.sv
// Bundle of CPU, I/O-engine and memory data-port signals around the arbiter.
interface data_port_arbiter_if #(
  parameter int WIDTH = 32
);
  // CPU (MEM stage) side
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rd;
  logic             cpu_stall;
  // I/O output engine side
  logic             io_req;
  logic             io_we;
  logic             io_last;
  logic [WIDTH-1:0] io_addr;
  logic [WIDTH-1:0] io_wd;
  logic             io_gnt;
  logic             io_err;
  logic [WIDTH-1:0] io_rd;
  // Memory data port
  logic             mem_we;
  logic [WIDTH-1:0] mem_a;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  // Requesters and memory model drive this side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_stall,
    output io_req, io_we, io_last, io_addr, io_wd,
    input  io_gnt, io_err, io_rd,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );

  // The arbiter sits on this side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_rd, cpu_stall,
    input  io_req, io_we, io_last, io_addr, io_wd,
    output io_gnt, io_err, io_rd,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );
endinterface

// File: rtl/data_port_arbiter.sv
// Arbitrates the memory data port between the CPU MEM stage and the I/O
// output engine. I/O bursts hold the port; a starved CPU gets one forced slot
// after MAXWAIT stalled cycles. I/O addresses outside the output segment are
// consumed but never written.
module data_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAXWAIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  data_port_arbiter_if.slave  bus
);

  localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

  arb_state_t state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       cpu_grant;
  logic       io_grant;
  logic       cpu_stall;
  logic       io_legal;

  assign io_legal = io_addr_legal(32'(bus.io_addr));

  // State and wait counter registers; reset abandons any open burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Grant decision, next state and wait-counter update.
  always_comb begin
    cpu_grant     = 1'b0;
    io_grant      = 1'b0;
    cpu_stall     = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.cpu_req) begin
          cpu_grant = 1'b1;
        end else if (bus.io_req) begin
          io_grant = 1'b1;
          // A single-beat burst never leaves IDLE.
          if (!bus.io_last) state_next = BURST;
        end
      end
      BURST: begin
        // The I/O beat also goes through when the counter is saturated but
        // nobody is waiting, so the burst can never deadlock.
        if (bus.io_req && ((wait_cnt_reg < WAIT_MAX) || !bus.cpu_req)) begin
          io_grant  = 1'b1;
          cpu_stall = bus.cpu_req;
          if (bus.io_last) state_next = IDLE;
        end else if (bus.cpu_req) begin
          // Forced slot (or idle I/O engine); the burst stays open and any
          // pending io_last is simply re-presented later.
          cpu_grant = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (cpu_grant || (state_next == IDLE)) begin
      wait_cnt_next = 4'd0;
    end else if (cpu_stall && (wait_cnt_reg < WAIT_MAX)) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  // Granted requester drives the memory port; all zero when nobody is granted.
  assign bus.mem_a  = cpu_grant ? bus.cpu_addr :
                      io_grant  ? bus.io_addr  : WIDTH'(0);
  assign bus.mem_wd = cpu_grant ? bus.cpu_wd   :
                      io_grant  ? bus.io_wd    : WIDTH'(0);
  assign bus.mem_we = (cpu_grant && bus.cpu_we) ||
                      (io_grant && bus.io_we && io_legal);

  assign bus.cpu_stall = cpu_stall;
  assign bus.cpu_rd    = cpu_grant ? bus.mem_rd : WIDTH'(0);
  assign bus.io_gnt    = io_grant;
  assign bus.io_err    = io_grant && !io_legal;
  assign bus.io_rd     = (io_grant && io_legal) ? bus.mem_rd : WIDTH'(0);

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a combinational memory model.
module tb_data_port_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   io_gnt_count;

  // MAXWAIT=4 preemption scenario, one entry per cycle.
  int beat_tab [11] = '{1, 2, 3, 4, 5, 6, 6, 7, 8, 9, 10};
  int creq_tab [11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int gnt_tab  [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  int stall_tab[11] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

  data_port_arbiter_if #(.WIDTH(32)) bus ();

  data_port_arbiter #(.WIDTH(32), .MAXWAIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory read data is a fixed function of the address.
  assign bus.mem_rd = bus.mem_a ^ RD_KEY;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wd = 0;
    bus.io_req = 0;  bus.io_we = 0;  bus.io_last = 0; bus.io_addr = 0; bus.io_wd = 0;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input arb_state_t exp);
    check_eq(tag, 32'(dut.state_reg), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"},  32'(bus.cpu_stall), 32'd0);
    check_eq({tag, "_io_gnt"}, 32'(bus.io_gnt),    32'd0);
    check_eq({tag, "_io_err"}, 32'(bus.io_err),    32'd0);
    check_eq({tag, "_mem_we"}, 32'(bus.mem_we),    32'd0);
    check_eq({tag, "_mem_a"},  bus.mem_a,          32'd0);
    check_eq({tag, "_mem_wd"}, bus.mem_wd,         32'd0);
    check_eq({tag, "_cpu_rd"}, bus.cpu_rd,         32'd0);
    check_eq({tag, "_io_rd"},  bus.io_rd,          32'd0);
  endtask

  initial begin
    clear_inputs();
    #1;

    // Reset with random inputs for two cycles, then requests low.
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_we = 1'($urandom_range(0, 1));
      bus.cpu_addr = $urandom; bus.cpu_wd = $urandom;
      bus.io_req = 1'($urandom_range(0, 1)); bus.io_we = 1'($urandom_range(0, 1));
      bus.io_last = 1'($urandom_range(0, 1)); bus.io_addr = $urandom; bus.io_wd = $urandom;
      step();
    end
    bus.cpu_req = 0; bus.io_req = 0;
    #2;
    $display("txn reset: requests low");
    check_all_zero("rst");
    check_state("rst_state", IDLE);
    reset = 0;
    clear_inputs();
    step();

    // CPU write at 40.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 40; bus.cpu_wd = 32'hDEAD;
    #2;
    $display("txn cpu write addr=40 data=0xDEAD");
    check_eq("cpuw_mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("cpuw_mem_a",  bus.mem_a,  32'd40);
    check_eq("cpuw_mem_wd", bus.mem_wd, 32'hDEAD);
    check_eq("cpuw_stall",  32'(bus.cpu_stall), 32'd0);
    check_eq("cpuw_cpu_rd", bus.cpu_rd, 32'd40 ^ RD_KEY);
    step();
    clear_inputs();

    // Three-beat I/O burst, 1056..1058.
    for (int b = 0; b < 3; b++) begin
      bus.io_req = 1; bus.io_we = 1; bus.io_addr = 32'(1056 + b);
      bus.io_wd = 32'(100 + b); bus.io_last = (b == 2);
      #2;
      $display("txn io beat %0d addr=%0d", b + 1, 1056 + b);
      check_eq($sformatf("burst3_gnt%0d", b), 32'(bus.io_gnt), 32'd1);
      check_eq($sformatf("burst3_we%0d", b),  32'(bus.mem_we), 32'd1);
      check_eq($sformatf("burst3_rd%0d", b),  bus.io_rd, 32'(1056 + b) ^ RD_KEY);
      step();
      check_state($sformatf("burst3_state%0d", b), (b < 2) ? BURST : IDLE);
    end
    clear_inputs();

    // Ten-beat burst with CPU asking from beat 2: forced slot after 4 stalls.
    io_gnt_count = 0;
    bus.cpu_addr = 200; bus.cpu_wd = 32'h55;
    for (int c = 0; c < 11; c++) begin
      bus.io_req = 1; bus.io_we = 1;
      bus.io_addr = 32'(1055 + beat_tab[c]); bus.io_wd = 32'(beat_tab[c]);
      bus.io_last = (beat_tab[c] == 10);
      bus.cpu_req = 1'(creq_tab[c]);
      #2;
      $display("txn preempt cycle %0d beat %0d cpu_req %0d", c, beat_tab[c], creq_tab[c]);
      check_eq($sformatf("pre_gnt%0d", c),   32'(bus.io_gnt),    32'(gnt_tab[c]));
      check_eq($sformatf("pre_stall%0d", c), 32'(bus.cpu_stall), 32'(stall_tab[c]));
      check_eq($sformatf("pre_mem_a%0d", c), bus.mem_a,
               (gnt_tab[c] == 1) ? 32'(1055 + beat_tab[c]) : 32'd200);
      if (bus.io_gnt) io_gnt_count++;
      step();
    end
    check_eq("pre_total_beats", 32'(io_gnt_count), 32'd10);
    check_state("pre_end_state", IDLE);
    clear_inputs();

    // Out-of-range beats (20, startIO flag) then an in-range beat.
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      logic        bad;
      a = (k == 0) ? 32'd20 : (k == 1) ? 32'(STARTIO_ADDR) : 32'd1100;
      bad = (k < 2);
      bus.io_req = 1; bus.io_we = 1; bus.io_last = 1; bus.io_addr = a; bus.io_wd = 32'h77;
      #2;
      $display("txn io range beat addr=%0d", a);
      check_eq($sformatf("rng_gnt%0d", k), 32'(bus.io_gnt), 32'd1);
      check_eq($sformatf("rng_err%0d", k), 32'(bus.io_err), 32'(bad));
      check_eq($sformatf("rng_we%0d", k),  32'(bus.mem_we), 32'(!bad));
      check_eq($sformatf("rng_rd%0d", k),  bus.io_rd, bad ? 32'd0 : (a ^ RD_KEY));
      step();
      check_state($sformatf("rng_state%0d", k), IDLE);
    end
    clear_inputs();

    // Simultaneous requests in IDLE: CPU first, I/O next cycle.
    bus.cpu_req = 1; bus.cpu_addr = 300;
    bus.io_req = 1; bus.io_last = 1; bus.io_addr = 1200;
    #2;
    $display("txn both request, cycle 1");
    check_eq("both_c1_mem_a", bus.mem_a, 32'd300);
    check_eq("both_c1_io_gnt", 32'(bus.io_gnt), 32'd0);
    check_eq("both_c1_stall", 32'(bus.cpu_stall), 32'd0);
    step();
    bus.cpu_req = 0;
    #2;
    $display("txn both request, cycle 2");
    check_eq("both_c2_io_gnt", 32'(bus.io_gnt), 32'd1);
    check_eq("both_c2_mem_a", bus.mem_a, 32'd1200);
    step();
    clear_inputs();

    // Reset during beat 2 of a five-beat burst.
    bus.io_req = 1; bus.io_we = 1; bus.io_addr = 1300;
    #2;
    $display("txn burst5 beat 1");
    step();
    check_state("rstb_beat1_state", BURST);
    bus.io_addr = 1301; reset = 1;
    #2;
    $display("txn burst5 beat 2 with reset");
    step();
    check_state("rstb_state", IDLE);
    reset = 0;
    clear_inputs();
    #2;
    check_all_zero("rstb_idle");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
